// File: rtl/stereo_ctrl_pkg.sv
// Shared types and default geometry for the stereo frame controller.
package stereo_ctrl_pkg;

  localparam int unsigned DefWidth   = 320;
  localparam int unsigned DefHeight  = 240;
  localparam int unsigned DefPipeLat = 8;
  localparam int unsigned PosW       = 9;
  localparam int unsigned StatW      = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/stereo_frame_ctrl_if.sv
// FIFO-side handshake between the frame controller (master) and the stereo datapath (slave).
interface stereo_frame_ctrl_if;

  logic left_empty_n;
  logic right_empty_n;
  logic out_full_n;
  logic enable;
  logic deq_L;
  logic deq_R;
  logic pad;
  logic enq_out;

  modport master (
    input  left_empty_n,
    input  right_empty_n,
    input  out_full_n,
    output enable,
    output deq_L,
    output deq_R,
    output pad,
    output enq_out
  );

  modport slave (
    output left_empty_n,
    output right_empty_n,
    output out_full_n,
    input  enable,
    input  deq_L,
    input  deq_R,
    input  pad,
    input  enq_out
  );

endinterface

// File: rtl/stereo_pos_counter.sv
// Column, line and per-line advance counters with terminal-count flags.
module stereo_pos_counter
  import stereo_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned HEIGHT   = DefHeight,
  parameter int unsigned PIPE_LAT = DefPipeLat
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            adv,
  input  logic            in_run,
  input  logic            in_flush,
  input  logic            in_done,
  output logic [PosW-1:0] col,
  output logic [PosW-1:0] row,
  output logic            col_last,
  output logic            ladv_last,
  output logic            row_last,
  output logic            lat_reached
);

  localparam int unsigned LineAdv = WIDTH + PIPE_LAT;
  localparam int unsigned LadvW   = $clog2(LineAdv);

  logic [LadvW-1:0] ladv_q, ladv_d;
  logic [PosW-1:0]  col_q, col_d;
  logic [PosW-1:0]  row_q, row_d;

  assign col_last    = (col_q == PosW'(WIDTH - 1));
  assign row_last    = (row_q == PosW'(HEIGHT - 1));
  assign ladv_last   = (ladv_q == LadvW'(LineAdv - 1));
  // Results leave the core only once the pipeline has been primed for this line.
  assign lat_reached = (ladv_q >= LadvW'(PIPE_LAT));

  always_comb begin
    ladv_d = ladv_q;
    col_d  = col_q;
    row_d  = row_q;
    if (adv) begin
      ladv_d = ladv_last ? '0 : ladv_q + 1'b1;
    end
    if (in_run && adv) begin
      col_d = col_last ? '0 : col_q + 1'b1;
    end
    if (in_flush && adv && ladv_last && !row_last) begin
      row_d = row_q + 1'b1;
    end
    if (in_done) begin
      row_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ladv_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else begin
      ladv_q <= ladv_d;
      col_q  <= col_d;
      row_q  <= row_d;
    end
  end

  assign col = col_q;
  assign row = row_q;

endmodule

// File: rtl/stereo_frame_ctrl.sv
// Frame sequencer for a stereo disparity core: feeds lines, flushes the pipeline, signals frame end.
// Optional stall statistics are built only when STEREO_CTRL_STATS_EN is defined.
module stereo_frame_ctrl
  import stereo_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned HEIGHT   = DefHeight,
  parameter int unsigned PIPE_LAT = DefPipeLat
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                start,
  stereo_frame_ctrl_if.master fifo,
  output logic                busy,
  output logic                frame_done,
  output logic [PosW-1:0]     col,
  output logic [PosW-1:0]     row,
  output logic [StatW-1:0]    stall_cnt
);

  state_e state_q, state_d;
  logic   sync_clr;
  logic   in_run, in_flush, in_done;
  logic   adv;
  logic   col_last, ladv_last, row_last, lat_reached;

  // clr behaves exactly like rst, so both collapse into one synchronous clear.
  assign sync_clr = rst | clr;

  assign in_run   = (state_q == StRun);
  assign in_flush = (state_q == StFlush);
  assign in_done  = (state_q == StDone);

  // Flush advances only need output space; pad replaces FIFO data.
  assign adv = (in_run & fifo.left_empty_n & fifo.right_empty_n & fifo.out_full_n) |
               (in_flush & fifo.out_full_n);

  assign fifo.enable  = adv;
  assign fifo.deq_L   = in_run & adv;
  assign fifo.deq_R   = in_run & adv;
  assign fifo.pad     = in_flush;
  assign fifo.enq_out = adv & lat_reached;

  assign busy       = (state_q != StIdle);
  assign frame_done = in_done;

  stereo_pos_counter #(
    .WIDTH    (WIDTH),
    .HEIGHT   (HEIGHT),
    .PIPE_LAT (PIPE_LAT)
  ) u_pos (
    .clk         (clk),
    .rst         (sync_clr),
    .adv         (adv),
    .in_run      (in_run),
    .in_flush    (in_flush),
    .in_done     (in_done),
    .col         (col),
    .row         (row),
    .col_last    (col_last),
    .ladv_last   (ladv_last),
    .row_last    (row_last),
    .lat_reached (lat_reached)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (adv && col_last) state_d = StFlush;
      StFlush: if (adv && ladv_last) state_d = row_last ? StDone : StRun;
      StDone:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_clr) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef STEREO_CTRL_STATS_EN
  logic [StatW-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (sync_clr) begin
      stall_q <= '0;
    end else if (in_run && !adv && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_stereo_frame_ctrl.sv
// Scoreboard bench for stereo_frame_ctrl: models the core pipeline and checks result alignment.
module tb_stereo_frame_ctrl;

  localparam int W = 4;
  localparam int H = 2;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst, clr, start;
  logic        busy, frame_done;
  logic [8:0]  col, row;
  logic [15:0] stall_cnt;

  stereo_frame_ctrl_if fifo ();

  stereo_frame_ctrl #(
    .WIDTH    (W),
    .HEIGHT   (H),
    .PIPE_LAT (L)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .start      (start),
    .fifo       (fifo),
    .busy       (busy),
    .frame_done (frame_done),
    .col        (col),
    .row        (row),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor-owned state: event counters and the core model.
  int cyc = 0;
  int cnt_en = 0, cnt_deq = 0, cnt_pad = 0, cnt_enq = 0, cnt_done = 0, sb_err = 0;
  int last_flush_cyc = 0, done_cyc = 0;
  int tag_next = 0;
  int exp_q[$];
  int pipe[L];
  int in_v, out_v, exp_v;

  initial for (int i = 0; i < L; i++) pipe[i] = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst === 1'b1 || clr === 1'b1) begin
      exp_q.delete();
      for (int i = 0; i < L; i++) pipe[i] = 0;
    end else begin
      if (fifo.deq_L !== fifo.deq_R) begin
        sb_err++;
        $display("FAIL sb_deq_pair: deq_L=%b deq_R=%b at cycle %0d", fifo.deq_L, fifo.deq_R, cyc);
      end
      if (fifo.enable === 1'b1) begin
        cnt_en++;
        if (fifo.deq_L === 1'b1) cnt_deq++;
        if (fifo.pad === 1'b1) begin
          cnt_pad++;
          last_flush_cyc = cyc;
        end
        in_v = 0;
        if (fifo.deq_L === 1'b1) begin
          tag_next++;
          in_v = tag_next;
          exp_q.push_back(tag_next);
        end
        out_v = pipe[L-1];
        for (int i = L - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = in_v;
        if (fifo.enq_out === 1'b1) begin
          cnt_enq++;
          if (exp_q.size() == 0) begin
            sb_err++;
            $display("FAIL sb_enq: got pixel %0d, required nothing pending", out_v);
          end else begin
            exp_v = exp_q.pop_front();
            if (out_v !== exp_v) begin
              sb_err++;
              $display("FAIL sb_enq: got pixel %0d, required %0d", out_v, exp_v);
            end
          end
        end else if (out_v != 0) begin
          sb_err++;
          $display("FAIL sb_drop: pixel %0d left core without enq_out", out_v);
        end
      end
      if (frame_done === 1'b1) begin
        cnt_done++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int d0;
    d0 = cnt_done;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (cnt_done != d0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if ({busy, frame_done, fifo.enable, fifo.deq_L, fifo.deq_R, fifo.pad, fifo.enq_out} !== 7'b0)
      $display("FAIL reset_outputs: got %b, required 0000000",
               {busy, frame_done, fifo.enable, fifo.deq_L, fifo.deq_R, fifo.pad, fifo.enq_out});
    else n_pass++;
    n_checks++;
    if (col !== 9'd0 || row !== 9'd0) $display("FAIL reset_pos: col=%0d row=%0d, required 0/0", col, row);
    else n_pass++;
    n_checks++;
    if (stall_cnt !== 16'd0) $display("FAIL reset_stall: got %0d, required 0", stall_cnt);
    else n_pass++;
    tick();
    rst = 1'b0;
    start = 1'b0;
    tick();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_start_priority: busy=%b, required 0", busy);
    else n_pass++;
    tick();
  endtask

  task automatic test_basic_frame();
    int en0, deq0, pad0, enq0, done0, sb0;
    bit ok;
    en0 = cnt_en; deq0 = cnt_deq; pad0 = cnt_pad; enq0 = cnt_enq; done0 = cnt_done; sb0 = sb_err;
    pulse_start();
    wait_done(ok);
    n_checks++;
    if (!ok) $display("FAIL basic_timeout: frame_done seen=0, required 1");
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (cnt_en - en0 !== 12) $display("FAIL basic_enable: got %0d, required 12", cnt_en - en0);
    else n_pass++;
    n_checks++;
    if (cnt_deq - deq0 !== 8) $display("FAIL basic_deq: got %0d, required 8", cnt_deq - deq0);
    else n_pass++;
    n_checks++;
    if (cnt_pad - pad0 !== 4) $display("FAIL basic_pad: got %0d, required 4", cnt_pad - pad0);
    else n_pass++;
    n_checks++;
    if (cnt_enq - enq0 !== 8) $display("FAIL basic_enq: got %0d, required 8", cnt_enq - enq0);
    else n_pass++;
    n_checks++;
    if (cnt_done - done0 !== 1) $display("FAIL basic_done_count: got %0d, required 1", cnt_done - done0);
    else n_pass++;
    n_checks++;
    if (done_cyc - last_flush_cyc !== 1)
      $display("FAIL basic_done_timing: got %0d cycles, required 1", done_cyc - last_flush_cyc);
    else n_pass++;
    n_checks++;
    if (sb_err - sb0 !== 0 || exp_q.size() !== 0)
      $display("FAIL basic_scoreboard: errors=%0d pending=%0d, required 0/0", sb_err - sb0, exp_q.size());
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || row !== 9'd0) $display("FAIL basic_idle: busy=%b row=%0d, required 0/0", busy, row);
    else n_pass++;
    tick();
  endtask

  task automatic test_input_stall();
    int en0, enq0, sb0;
    bit ok, hit;
    en0 = cnt_en; enq0 = cnt_enq; sb0 = sb_err;
    hit = 1'b0;
    pulse_start();
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      hit = busy && !fifo.pad && row == 9'd0 && col == 9'd2;
    end
    n_checks++;
    if (!hit) $display("FAIL stall_reach: col 2 reached=0, required 1");
    else n_pass++;
    tick();
    fifo.left_empty_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({fifo.enable, fifo.deq_L, fifo.deq_R, fifo.enq_out} !== 4'b0)
        $display("FAIL stall_outputs: got %b, required 0000",
                 {fifo.enable, fifo.deq_L, fifo.deq_R, fifo.enq_out});
      else n_pass++;
      n_checks++;
      if (col !== 9'd3) $display("FAIL stall_col: got %0d, required 3", col);
      else n_pass++;
      tick();
    end
    fifo.left_empty_n = 1'b1;
    wait_done(ok);
    @(negedge clk);
    n_checks++;
    if (!ok || cnt_en - en0 !== 12 || cnt_enq - enq0 !== 8)
      $display("FAIL stall_totals: done=%0d enable=%0d enq=%0d, required 1/12/8",
               ok, cnt_en - en0, cnt_enq - enq0);
    else n_pass++;
    n_checks++;
    if (sb_err - sb0 !== 0) $display("FAIL stall_scoreboard: got %0d errors, required 0", sb_err - sb0);
    else n_pass++;
    tick();
  endtask

  task automatic test_flush_backpressure();
    int enq0, done0, sb0;
    bit ok, hit;
    enq0 = cnt_enq; done0 = cnt_done; sb0 = sb_err;
    hit = 1'b0;
    pulse_start();
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      hit = (fifo.pad === 1'b1);
    end
    n_checks++;
    if (!hit) $display("FAIL flush_reach: pad seen=0, required 1");
    else n_pass++;
    tick();
    fifo.out_full_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({fifo.pad, fifo.enable, fifo.enq_out, fifo.deq_L} !== 4'b1000)
        $display("FAIL flush_hold: pad/en/enq/deq=%b, required 1000",
                 {fifo.pad, fifo.enable, fifo.enq_out, fifo.deq_L});
      else n_pass++;
      tick();
    end
    fifo.out_full_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({fifo.pad, fifo.enable, fifo.enq_out} !== 3'b111)
      $display("FAIL flush_resume: pad/en/enq=%b, required 111", {fifo.pad, fifo.enable, fifo.enq_out});
    else n_pass++;
    tick();
    wait_done(ok);
    @(negedge clk);
    n_checks++;
    if (!ok || cnt_enq - enq0 !== 8 || cnt_done - done0 !== 1)
      $display("FAIL flush_totals: done=%0d enq=%0d, required 1/8", cnt_done - done0, cnt_enq - enq0);
    else n_pass++;
    n_checks++;
    if (sb_err - sb0 !== 0) $display("FAIL flush_scoreboard: got %0d errors, required 0", sb_err - sb0);
    else n_pass++;
    tick();
  endtask

  task automatic test_clr();
    int enq0, done0, sb0;
    bit ok, hit;
    done0 = cnt_done;
    hit = 1'b0;
    pulse_start();
    for (int i = 0; i < 80 && !hit; i++) begin
      @(negedge clk);
      hit = busy && !fifo.pad && row == 9'd1 && col == 9'd1;
    end
    tick();
    clr = 1'b1;
    @(negedge clk);
    n_checks++;
    if (!hit || row !== 9'd1 || col !== 9'd2)
      $display("FAIL clr_point: reached=%0d row=%0d col=%0d, required 1/1/2", hit, row, col);
    else n_pass++;
    tick();
    clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, frame_done, fifo.enable, fifo.deq_L, fifo.deq_R, fifo.pad, fifo.enq_out} !== 7'b0)
      $display("FAIL clr_outputs: got %b, required 0000000",
               {busy, frame_done, fifo.enable, fifo.deq_L, fifo.deq_R, fifo.pad, fifo.enq_out});
    else n_pass++;
    n_checks++;
    if (col !== 9'd0 || row !== 9'd0 || cnt_done !== done0)
      $display("FAIL clr_state: col=%0d row=%0d done=%0d, required 0/0/0", col, row, cnt_done - done0);
    else n_pass++;
    tick();
    enq0 = cnt_enq; done0 = cnt_done; sb0 = sb_err;
    pulse_start();
    wait_done(ok);
    @(negedge clk);
    n_checks++;
    if (!ok || cnt_enq - enq0 !== 8 || cnt_done - done0 !== 1 || sb_err - sb0 !== 0)
      $display("FAIL clr_restart: done=%0d enq=%0d sb_errors=%0d, required 1/8/0",
               cnt_done - done0, cnt_enq - enq0, sb_err - sb0);
    else n_pass++;
    tick();
  endtask

  task automatic test_start_while_busy();
    int done0;
    bit ok, hit;
    done0 = cnt_done;
    hit = 1'b0;
    pulse_start();
    tick();
    tick();
    pulse_start();
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      hit = (fifo.pad === 1'b1);
    end
    tick();
    pulse_start();
    wait_done(ok);
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    n_checks++;
    if (!ok || cnt_done - done0 !== 1)
      $display("FAIL busy_start_done: got %0d frame_done, required 1", cnt_done - done0);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL busy_start_idle: busy=%b, required 0", busy);
    else n_pass++;
    tick();
  endtask

  task automatic test_stats();
    int enq0, exp_stall;
    bit ok, hit;
`ifdef STEREO_CTRL_STATS_EN
    exp_stall = 5;
`else
    exp_stall = 0;
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== 16'd0) $display("FAIL stats_rst: got %0d, required 0", stall_cnt);
    else n_pass++;
    tick();
    enq0 = cnt_enq;
    hit = 1'b0;
    pulse_start();
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      hit = busy && !fifo.pad && row == 9'd0 && col == 9'd1;
    end
    tick();
    fifo.right_empty_n = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    fifo.right_empty_n = 1'b1;
    wait_done(ok);
    @(negedge clk);
    n_checks++;
    if (!hit || !ok || cnt_enq - enq0 !== 8)
      $display("FAIL stats_frame: reached=%0d done=%0d enq=%0d, required 1/1/8", hit, ok, cnt_enq - enq0);
    else n_pass++;
    n_checks++;
    if (stall_cnt !== 16'(exp_stall)) $display("FAIL stats_count: got %0d, required %0d", stall_cnt, exp_stall);
    else n_pass++;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    start = 1'b0;
    fifo.left_empty_n  = 1'b1;
    fifo.right_empty_n = 1'b1;
    fifo.out_full_n    = 1'b1;
    test_reset();
    test_basic_frame();
    test_input_stall();
    test_flush_backpressure();
    test_clr();
    test_start_while_busy();
    test_stats();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
